score_keeper_bcd: RTL

- Parametrised successor to the two-digit score tracker.
- Keeps the current score as a native multi-digit BCD counter, with no binary-to-BCD compare chain.
- Tracks the high score and runs an explicit IDLE/PLAY/OVER game FSM.
- Time-multiplexes the selected score onto a single BCD digit bus with one-hot digit enables for the seven-segment decoders.
- Sits between the collision posedge detectors and the ssdec instances in top.

---
 rtl/score_keeper_bcd.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/score_keeper_bcd.sv
// Score keeper with native BCD current/high scores, IDLE/PLAY/OVER game FSM,
// and a time-multiplexed single-digit scan bus with optional leading-zero blanking.
module score_keeper_bcd #(
  parameter int NUM_DIGITS = 2,
  parameter int MAX_SCORE  = 50,
  parameter int SCAN_DIV   = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic                    start,
  input  logic                    goodColl,
  input  logic                    badColl,
  input  logic                    showHigh,
  output logic [4*NUM_DIGITS-1:0] curr_bcd,
  output logic [4*NUM_DIGITS-1:0] high_bcd,
  output logic [3:0]              disp_digit,
  output logic [NUM_DIGITS-1:0]   scan_en,
  output logic                    playing,
  output logic                    isGameComplete,
  output logic                    newHigh,
  output logic [1:0]              dbg_state
);

  localparam int W     = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam int             MAX_LIMIT = pow10(NUM_DIGITS) - 1;
  localparam logic [W-1:0]   MAX_BCD   = to_bcd(MAX_SCORE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("score_keeper_bcd: NUM_DIGITS must be 1..8");
    end
    if (MAX_SCORE < 1 || MAX_SCORE > MAX_LIMIT) begin : g_bad_max
      $error("score_keeper_bcd: MAX_SCORE out of range for NUM_DIGITS");
    end
    if (SCAN_DIV < 1) begin : g_bad_div
      $error("score_keeper_bcd: SCAN_DIV must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t       state;
  logic [W-1:0] curr_inc;

  assign curr_inc       = bcd_inc(curr_bcd);
  assign playing        = (state == S_PLAY);
  assign isGameComplete = (state == S_OVER);
  assign dbg_state      = state;

  // Packed BCD compares as an unsigned vector exactly like a digitwise MSD-first compare.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= S_IDLE;
      curr_bcd <= '0;
      high_bcd <= '0;
      newHigh  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            state    <= S_PLAY;
            curr_bcd <= '0;
            newHigh  <= 1'b0;
          end
        end
        S_PLAY: begin
          if (badColl) begin
            state <= S_OVER;
            if (curr_bcd > high_bcd) begin
              high_bcd <= curr_bcd;
              newHigh  <= 1'b1;
            end
          end else if (goodColl) begin
            curr_bcd <= curr_inc;
            if (curr_inc == MAX_BCD) begin
              state <= S_OVER;
              if (curr_inc > high_bcd) begin
                high_bcd <= curr_inc;
                newHigh  <= 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [IDX_W-1:0]      scan_idx;
  logic [DIV_W-1:0]      scan_div;
  logic [W-1:0]          disp_src;
  logic [3:0]            sel_digit;
  logic [NUM_DIGITS-1:0] sel_onehot;
  logic                  upper_nz;
  logic                  blank;

  assign disp_src = (state == S_PLAY && !showHigh) ? curr_bcd : high_bcd;

  always_comb begin
    sel_digit  = 4'd0;
    sel_onehot = '0;
    upper_nz   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == scan_idx) begin
        sel_digit     = disp_src[i*4 +: 4];
        sel_onehot[i] = 1'b1;
      end
      if (IDX_W'(i) >= scan_idx && disp_src[i*4 +: 4] != 4'd0) upper_nz = 1'b1;
    end
    blank = (BLANK_LZ != 0) && (scan_idx != '0) && !upper_nz;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      scan_idx   <= '0;
      scan_div   <= '0;
      disp_digit <= 4'd0;
      scan_en    <= NUM_DIGITS'(1);
    end else begin
      disp_digit <= sel_digit;
      scan_en    <= blank ? '0 : sel_onehot;
      if (scan_div == LAST_DIV) begin
        scan_div <= '0;
        scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_div <= scan_div + 1'b1;
      end
    end
  end

endmodule
